dsp48_mac_sequencer: RTL
========================

# dsp48_mac_sequencer

Command-driven controller for one DSP48 slice configured as a multiply-accumulator. It accepts a job length, streams that many A/B operand pairs into the slice with OPMODE timed to meet each product at the post-adder, and captures the accumulated P. It returns the sum on a valid/ready result port. It sits between the datapath FIFOs and the DSP slice, and drives the slice's operand and OPMODE inputs.

## Interface
- MULT_LAT, 2, cycles from dsp_a/dsp_b to the multiplier output at the post-adder input (A1/B1 register plus M register)
- OPM_LAT, 1, OPMODE register depth inside the slice; must satisfy MULT_LAT ≥ OPM_LAT
- P_LAT, 1, P/CARRYOUT register depth inside the slice
- LEN_W, 16, width of cmd_len
- CLK  in  1  clock; all logic on rising edge
- RSTB  in  1  reset, asynchronous, active-high; clock CLK
- cmd_valid / cmd_ready  in/out  1  job handshake
- cmd_len  in  LEN_W  number of products N (unsigned)
- op_valid / op_ready  in/out  1  operand handshake
- op_a, op_b  in  18  unsigned operands
- dsp_a, dsp_b, dsp_d  out  18  slice operands; dsp_d is constant 0 (pre-adder passes B)
- dsp_opmode  out  8  slice OPMODE
- dsp_p  in  48  slice P
- dsp_carryout  in  1  slice CARRYOUT
- res_valid / res_ready  out/in  1  result handshake
- res_data  out  48  accumulated sum mod 2^48
- res_ovf  out  1  sticky carry-out of the job

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On a cmd handshake, load rem=cmd_len. Go to ISSUE, or to DONE if cmd_len=0 (res_data=0, no operands consumed).
  - ISSUE: op_ready=1. Each op handshake registers op_a/op_b onto dsp_a/dsp_b and decrements rem. After the handshake that takes rem to 0, go to DRAIN.
  - DRAIN: count MULT_LAT+P_LAT cycles, then capture dsp_p into res_data and go to DONE.
  - DONE: res_valid=1. res_data and res_ovf are held stable until res_ready, then go to IDLE.
- Only one job is in flight; cmd_ready=0 outside IDLE.
- Slot tagging: each cycle while ISSUE/DRAIN is active, the dsp_a/dsp_b slot is tagged FIRST (first product of the job), NEXT (later product) or BUBBLE (no handshake the previous cycle).
- Tags travel down a (MULT_LAT−OPM_LAT)-deep shift line and drive dsp_opmode:
  - FIRST = 8'h01 (X=M, Z=0)
  - NEXT = 8'h09 (X=M, Z=P)
  - BUBBLE = 8'h08 (X=0, Z=P; P holds)
- Outside a job dsp_opmode=8'h00 (P cleared to 0). Bits 7:4 are always 0: add, pre-add, carry-in 0.
- dsp_a/dsp_b hold their last value during bubbles; the value is irrelevant because X=0.
- Overflow: res_ovf = OR of dsp_carryout over every cycle a FIRST/NEXT tag is at P output (tag delayed MULT_LAT+P_LAT). It is cleared on command acceptance.

## Timing
- Op handshake at cycle t: dsp_a/dsp_b valid at t+1.
  - Matching opmode on dsp_opmode at t+1+MULT_LAT−OPM_LAT.
  - Product in dsp_p at t+1+MULT_LAT+P_LAT.
- Last op handshake at tL: res_valid rises at tL+2+MULT_LAT+P_LAT (default tL+5).
- cmd_len=0: res_valid rises 1 cycle after the cmd handshake.
- Back-to-back operands give 1 product/cycle; bubbles of any length are legal.
- A res handshake and a new cmd in the same cycle: the cmd is not accepted (cmd_ready is still 0); it is accepted the following cycle.
- Reset values: cmd_ready=0 during reset and 1 after. op_ready=0, res_valid=0, res_data=0, res_ovf=0, dsp_a=dsp_b=dsp_d=0, dsp_opmode=8'h00, state IDLE, shift lines cleared.
- RSTB mid-job aborts the job. No result is produced. The next job starts clean because opmode 8'h00 clears P before its FIRST slot.

## Configuration
- MAC_SEQ_OVF_EN defined: carry-out tag delay line and sticky res_ovf logic are present, as described above.
- MAC_SEQ_OVF_EN undefined: that logic is removed, res_ovf is tied 0, and dsp_carryout is ignored. All other behaviour is identical.

## Test plan
- len=3, ops (2,3),(4,5),(6,7) back-to-back → res_data=68, res_ovf=0, res_valid 5 cycles after the last op handshake.
- Same job with 2-cycle op_valid gaps → res_data=68; dsp_opmode shows 8'h08 in the bubble slots and 8'h01 only once.
- len=0 → op_ready never asserts; res_valid 1 cycle later with res_data=0.
- len=2, ops (10,10),(1,1), res_ready low for 5 cycles → res_data=101 stable, cmd_ready=0 until the res handshake, then 1 next cycle.
- len=4097, all ops (3FFFF,3FFFF) → res_data=(4097·(2^18−1)^2) mod 2^48. res_ovf=1 with MAC_SEQ_OVF_EN, 0 without.
- RSTB pulse after 1 of 3 ops → all outputs at reset values; next job len=1 (5,5) → res_data=25.

Source files
------------

// File: rtl/dsp48_mac_sequencer.sv
// dsp48_mac_sequencer
//   Command-driven controller for one DSP48 slice used as a multiply-accumulator.
//   A job of cmd_len operand pairs is streamed into the slice. OPMODE tags are
//   delayed so that each tag meets its product at the post-adder. The accumulated
//   P is captured and returned on a valid/ready result port.
//
// Ports
//   CLK, RSTB                 clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_len  job handshake and product count (0 is legal)
//   op_valid/ready, op_a/b    operand handshake, 18-bit unsigned operands
//   dsp_a/b/d, dsp_opmode     slice operand and OPMODE drives (dsp_d is always 0)
//   dsp_p, dsp_carryout       slice P output and carry-out
//   res_valid/ready           result handshake
//   res_data, res_ovf         sum mod 2^48 and sticky carry-out of the job
//
// Configuration
//   MAC_SEQ_OVF_EN  when defined, adds the carry-out tag line and sticky res_ovf.
//                   When undefined, res_ovf is 0 and dsp_carryout is ignored.
module dsp48_mac_sequencer #(
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned OPM_LAT  = 1,
  parameter int unsigned P_LAT    = 1,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [17:0]      dsp_d,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             res_ovf
);

  localparam int unsigned OpmDly   = MULT_LAT - OPM_LAT;
  localparam int unsigned DrainCnt = MULT_LAT + P_LAT;
  localparam int unsigned DrainW   = $clog2(DrainCnt + 2);
`ifdef MAC_SEQ_OVF_EN
  localparam int unsigned LineLen  = MULT_LAT + P_LAT;
`else
  localparam int unsigned LineLen  = OpmDly;
`endif
  localparam int unsigned LineDepth = (LineLen == 0) ? 1 : LineLen;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;
  typedef enum logic [1:0] {TagNone, TagFirst, TagNext, TagBubble} tag_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  tag_e               slot_q, slot_d;
  tag_e               line_q [LineDepth];
  tag_e               opm_tag;
  logic [17:0]        a_q, b_q;
  logic [47:0]        res_data_q, res_data_d;
  logic               alive_q;
  logic               cmd_fire, op_fire;

  assign cmd_ready = (state_q == StIdle) && alive_q;
  assign op_ready  = (state_q == StIssue);
  assign res_valid = (state_q == StDone);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign op_fire   = op_valid && op_ready;
  assign dsp_a     = a_q;
  assign dsp_b     = b_q;
  assign dsp_d     = '0;
  assign res_data  = res_data_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    first_d    = first_q;
    drain_d    = drain_q;
    res_data_d = res_data_q;
    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          rem_d   = cmd_len;
          first_d = 1'b1;
          if (cmd_len == '0) begin
            state_d    = StDone;
            res_data_d = '0;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (op_fire) begin
          rem_d   = rem_q - LEN_W'(1);
          first_d = 1'b0;
          if (rem_q == LEN_W'(1)) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        // Last product reaches P after MULT_LAT+P_LAT cycles in this state.
        if (drain_q == DrainW'(DrainCnt)) begin
          res_data_d = dsp_p;
          state_d    = StDone;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Tag for the operand slot that dsp_a/dsp_b present next cycle.
    if (op_fire) begin
      slot_d = first_q ? TagFirst : TagNext;
    end else if (state_d == StIssue || state_d == StDrain) begin
      slot_d = TagBubble;
    end else begin
      slot_d = TagNone;
    end
  end

  always_ff @(posedge CLK or posedge RSTB) begin
    if (RSTB) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      first_q    <= 1'b0;
      drain_q    <= '0;
      slot_q     <= TagNone;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      alive_q    <= 1'b0;
      for (int i = 0; i < int'(LineDepth); i++) line_q[i] <= TagNone;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      drain_q    <= drain_d;
      slot_q     <= slot_d;
      res_data_q <= res_data_d;
      alive_q    <= 1'b1;
      if (op_fire) begin
        a_q <= op_a;
        b_q <= op_b;
      end
      line_q[0] <= slot_q;
      for (int i = 1; i < int'(LineDepth); i++) line_q[i] <= line_q[i-1];
    end
  end

  generate
    if (OpmDly == 0) begin : g_opm_direct
      assign opm_tag = slot_q;
    end else begin : g_opm_line
      assign opm_tag = line_q[OpmDly-1];
    end
  endgenerate

  always_comb begin
    case (opm_tag)
      TagFirst:  dsp_opmode = 8'h01;
      TagNext:   dsp_opmode = 8'h09;
      TagBubble: dsp_opmode = 8'h08;
      default:   dsp_opmode = 8'h00;
    endcase
  end

`ifdef MAC_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  tag_e p_tag;

  // Tag aligned with the P register output.
  assign p_tag = line_q[MULT_LAT+P_LAT-1];

  always_comb begin
    ovf_d = ovf_q;
    if ((p_tag == TagFirst || p_tag == TagNext) && dsp_carryout) ovf_d = 1'b1;
    if (cmd_fire) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RSTB) begin
    if (RSTB) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign res_ovf = ovf_q;
`else
  logic unused_carryout;
  assign unused_carryout = dsp_carryout;
  assign res_ovf         = 1'b0;
`endif

endmodule
